pri_decoder_stream: RTL and testbench

Streaming 4-to-16 binary-to-one-hot decoder: the receiving end for the 4-bit codes produced by the team's priority encoders. It accepts binary codes over a valid/ready handshake and buffers them in a small FIFO. It presents each code as a 16-bit one-hot word on a second valid/ready handshake. Typical placement is after an encoder stage crossing a pipeline boundary, where the consumer may back-pressure.

---
 rtl/pri_decoder_stream.sv | 133 +++++++++++++
 tb/tb_pri_decoder_stream.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pri_decoder_stream.sv
// pri_decoder_stream: 4-to-16 binary-to-one-hot decoder behind a small FIFO,
// with valid/ready handshakes on both sides.
// Optional feature macro: PRI_DECODER_ZERO_CNT_EN builds the saturating
// zero_count counter and its zero_clr input; otherwise zero_count is 8'h00.
module pri_decoder_stream #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  binary_in,
  input  logic        enable,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] decoder_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  zero_count,
  input  logic        zero_clr
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } occ_state_e;

  occ_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WORD_W-1:0]   mem [FIFO_DEPTH];
  logic [WORD_W-1:0]   word_c;
  logic                push_c;
  logic                pop_c;

  // Handshake flags come straight from the occupancy state register.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign push_c    = in_valid && in_ready;
  assign pop_c     = out_valid && out_ready;

  // Decode at accept time; code 0 or enable low means "no request".
  always_comb begin
    word_c = '0;
    if (enable && (binary_in != 4'd0)) begin
      word_c = WORD_W'(1) << binary_in;
    end
  end

  // Head of FIFO, forced to zero while nothing is buffered.
  assign decoder_out = out_valid ? mem[rd_ptr_q] : '0;

  // Occupancy FSM: next state, count and pointer updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case (state_q)
      ST_EMPTY: begin
        if (push_c) begin
          cnt_d   = CNT_W'(1);
          state_d = (CNT_W'(1) == CNT_W'(FIFO_DEPTH)) ? ST_FULL : ST_PARTIAL;
        end
      end
      ST_PARTIAL: begin
        if (push_c && !pop_c) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_d == CNT_W'(FIFO_DEPTH)) ? ST_FULL : ST_PARTIAL;
        end else if (pop_c && !push_c) begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = (cnt_d == CNT_W'(0)) ? ST_EMPTY : ST_PARTIAL;
        end
      end
      ST_FULL: begin
        if (pop_c) begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = (cnt_d == CNT_W'(0)) ? ST_EMPTY : ST_PARTIAL;
        end
      end
      default: begin
        state_d  = ST_EMPTY;
        cnt_d    = '0;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
      end
    endcase
  end

  // Occupancy state, count and pointer registers; reset flushes the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_EMPTY;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care while marked empty.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= word_c;
  end

`ifdef PRI_DECODER_ZERO_CNT_EN
  // Saturating count of accepted all-zero words; clear beats increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_count <= 8'h00;
    end else if (zero_clr) begin
      zero_count <= 8'h00;
    end else if (push_c && (word_c == '0) && (zero_count != 8'hFF)) begin
      zero_count <= zero_count + 8'd1;
    end
  end
`else
  logic unused_zero_clr;
  assign unused_zero_clr = zero_clr;
  assign zero_count      = 8'h00;
`endif

endmodule

// File: tb/tb_pri_decoder_stream.sv
// Directed self-checking bench for pri_decoder_stream (FIFO_DEPTH = 2).
module tb_pri_decoder_stream;

`ifdef PRI_DECODER_ZERO_CNT_EN
  localparam bit ZC_EN = 1'b1;
`else
  localparam bit ZC_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [3:0]  binary_in;
  logic        enable;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] decoder_out;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  zero_count;
  logic        zero_clr;

  int pass_cnt;
  int total_cnt;
  int zc_model;

  logic [15:0] exp_tab [16];

  pri_decoder_stream #(.FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .binary_in   (binary_in),
    .enable      (enable),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .decoder_out (decoder_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .zero_count  (zero_count),
    .zero_clr    (zero_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int zc_inc(input int v);
    if (!ZC_EN) return 0;
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      binary_in = 4'($urandom_range(0, 15));
      enable    = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      zero_clr  = 1'($urandom_range(0, 1));
      step();
    end
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++;
    if (decoder_out !== 16'h0000) $display("FAIL reset_dout: got %h want 0000", decoder_out); else pass_cnt++;
    total_cnt++;
    if (zero_count !== 8'h00) $display("FAIL reset_zero_count: got %h want 00", zero_count); else pass_cnt++;
    zc_model  = 0;
    // release and present a code for the very first edge
    binary_in = 4'd6; enable = 1'b1; in_valid = 1'b1; out_ready = 1'b1; zero_clr = 1'b0;
    reset_n   = 1'b1;
    step();
    total_cnt++;
    if (out_valid !== 1'b1 || decoder_out !== 16'h0040)
      $display("FAIL reset_first_accept: got v=%b %h want v=1 0040", out_valid, decoder_out);
    else pass_cnt++;
    in_valid = 1'b0;
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_first_drain: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_sweep();
    exp_tab = '{16'h0000, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080,
                16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'h1000, 16'h2000, 16'h4000, 16'h8000};
    out_ready = 1'b1; enable = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      binary_in = 4'(i);
      step();
      if (i == 0) zc_model = zc_inc(zc_model);
      total_cnt++;
      if (out_valid !== 1'b1 || decoder_out !== exp_tab[i] || in_ready !== 1'b1)
        $display("FAIL sweep[%0d]: got v=%b r=%b %h want v=1 r=1 %h",
                 i, out_valid, in_ready, decoder_out, exp_tab[i]);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    step();
    total_cnt++;
    if (out_valid !== 1'b0 || decoder_out !== 16'h0000)
      $display("FAIL sweep_drain: got v=%b %h want v=0 0000", out_valid, decoder_out);
    else pass_cnt++;
    total_cnt++;
    if (zero_count !== 8'(zc_model)) $display("FAIL sweep_zero_count: got %0d want %0d", zero_count, zc_model);
    else pass_cnt++;
  endtask

  task automatic test_enable_low();
    out_ready = 1'b1; enable = 1'b0; in_valid = 1'b1; binary_in = 4'd9;
    step();
    zc_model = zc_inc(zc_model);
    in_valid = 1'b0; enable = 1'b1;
    total_cnt++;
    if (out_valid !== 1'b1 || decoder_out !== 16'h0000)
      $display("FAIL enable_low_dout: got v=%b %h want v=1 0000", out_valid, decoder_out);
    else pass_cnt++;
    total_cnt++;
    if (zero_count !== 8'(zc_model)) $display("FAIL enable_low_zero_count: got %0d want %0d", zero_count, zc_model);
    else pass_cnt++;
    step();
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0; enable = 1'b1; in_valid = 1'b1; binary_in = 4'd3;
    step();
    total_cnt++;
    if (in_ready !== 1'b1 || decoder_out !== 16'h0008)
      $display("FAIL bp_first: got r=%b %h want r=1 0008", in_ready, decoder_out);
    else pass_cnt++;
    binary_in = 4'd5;
    step();
    total_cnt++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || decoder_out !== 16'h0008)
      $display("FAIL bp_full: got r=%b v=%b %h want r=0 v=1 0008", in_ready, out_valid, decoder_out);
    else pass_cnt++;
    binary_in = 4'd7;
    step();
    total_cnt++;
    if (in_ready !== 1'b0 || decoder_out !== 16'h0008)
      $display("FAIL bp_hold: got r=%b %h want r=0 0008", in_ready, decoder_out);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++;
    if (in_ready !== 1'b1 || decoder_out !== 16'h0020)
      $display("FAIL bp_release1: got r=%b %h want r=1 0020", in_ready, decoder_out);
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || decoder_out !== 16'h0080)
      $display("FAIL bp_release2: got v=%b %h want v=1 0080", out_valid, decoder_out);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b0 || decoder_out !== 16'h0000)
      $display("FAIL bp_drain: got v=%b %h want v=0 0000", out_valid, decoder_out);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    out_ready = 1'b1; enable = 1'b1; in_valid = 1'b1; binary_in = 4'd0; zero_clr = 1'b0;
    for (int n = 0; n < 260; n++) begin
      step();
      zc_model = zc_inc(zc_model);
      if (n == 199) begin
        total_cnt++;
        if (zero_count !== 8'(zc_model)) $display("FAIL sat_partial: got %0d want %0d", zero_count, zc_model);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (zero_count !== (ZC_EN ? 8'hFF : 8'h00))
      $display("FAIL sat_full: got %h want %h", zero_count, ZC_EN ? 8'hFF : 8'h00);
    else pass_cnt++;
    zero_clr = 1'b1;
    step();
    zero_clr = 1'b0;
    zc_model = 0;
    total_cnt++;
    if (zero_count !== 8'h00) $display("FAIL sat_clear: got %h want 00", zero_count); else pass_cnt++;
    step();
    zc_model = zc_inc(zc_model);
    in_valid = 1'b0;
    total_cnt++;
    if (zero_count !== 8'(zc_model)) $display("FAIL sat_after_clear: got %0d want %0d", zero_count, zc_model);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; enable = 1'b1; in_valid = 1'b1; binary_in = 4'd1;
    step();
    binary_in = 4'd2;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b0 || decoder_out !== 16'h0002)
      $display("FAIL mid_prefill: got r=%b %h want r=0 0002", in_ready, decoder_out);
    else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || decoder_out !== 16'h0000 || zero_count !== 8'h00)
      $display("FAIL mid_async: got v=%b r=%b %h zc=%h want v=0 r=1 0000 zc=00",
               out_valid, in_ready, decoder_out, zero_count);
    else pass_cnt++;
    step();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    step();
    total_cnt++;
    if (out_valid !== 1'b0 || decoder_out !== 16'h0000)
      $display("FAIL mid_no_stale: got v=%b %h want v=0 0000", out_valid, decoder_out);
    else pass_cnt++;
    in_valid = 1'b1; binary_in = 4'd4;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || decoder_out !== 16'h0010)
      $display("FAIL mid_resume: got v=%b %h want v=1 0010", out_valid, decoder_out);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL mid_resume_drain: got %b want 0", out_valid); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    zc_model  = 0;
    reset_n   = 1'b0;
    binary_in = 4'd0;
    enable    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    zero_clr  = 1'b0;
    test_reset();
    test_sweep();
    test_enable_low();
    test_back_pressure();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
